// File: rtl/jups_core_pkg.sv
// Shared definitions for the JUPS core: process/OS state encoding and core-wide constants.
package jups_core_pkg;

    typedef enum logic [1:0] {
        USER   = 2'd0,
        SWITCH = 2'd1,
        OS     = 2'd2
    } core_state_e;

    localparam int QUANTUM  = 20;
    localparam int CNT_W    = 5;
    localparam int PC_W     = 32;
    localparam int SW_CNT_W = 8;

    // First OS instruction executed after a context switch; the PC controller jumps here.
    localparam logic [PC_W-1:0] OS_ENTRY_PC = 32'h0000_0003;

endpackage

// File: rtl/quantum_counter.sv
// Time-slice counter for the running user process; captures the interrupted PC on a
// context switch and holds the slice count at zero until the OS returns control.
module quantum_counter
    import jups_core_pkg::*;
#(
    parameter int Q_LEN     = QUANTUM,
    parameter int Q_CNT_W   = CNT_W,
    parameter int Q_PC_W    = PC_W,
    parameter int Q_SW_W    = SW_CNT_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                instr_retire,
    input  logic                stall,
    input  logic                enable_so,
    input  logic                end_proc,
    input  logic                so_return,
    input  logic [Q_PC_W-1:0]   pc_curr,
    output logic [Q_CNT_W-1:0]  pc_counter,
    output logic                user_mode,
    output logic [Q_PC_W-1:0]   saved_pc,
    output logic                saved_pc_valid,
    output logic                preempted,
    output logic [Q_SW_W-1:0]   switch_count
);

    localparam logic [Q_CNT_W-1:0] QUANTUM_C = Q_CNT_W'(Q_LEN);

    core_state_e          state_q, state_d;
    logic [Q_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 user_mode_q, user_mode_d;
    logic [Q_PC_W-1:0]    saved_pc_q, saved_pc_d;
    logic                 saved_valid_q, saved_valid_d;
    logic                 preempted_q, preempted_d;
    logic [Q_SW_W-1:0]    sw_cnt_q, sw_cnt_d;

    always_comb begin
        // NOTE: every signal gets a hold value first so no path through the case infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        saved_pc_d    = saved_pc_q;
        saved_valid_d = saved_valid_q;
        preempted_d   = preempted_q;
        sw_cnt_d      = sw_cnt_q;

        unique case (state_q)
            USER: begin
                if (enable_so) begin
                    // Switch wins over a same-cycle retire; so_return is meaningless here.
                    state_d       = SWITCH;
                    saved_pc_d    = pc_curr;
                    saved_valid_d = 1'b1;
                    preempted_d   = (cnt_q == QUANTUM_C) && !end_proc;
                    sw_cnt_d      = sw_cnt_q + Q_SW_W'(1);
                    cnt_d         = '0;
                end else if (instr_retire && !stall && (cnt_q != QUANTUM_C)) begin
                    cnt_d = cnt_q + Q_CNT_W'(1);
                end
            end
            SWITCH: begin
                state_d = OS;
                cnt_d   = '0;
            end
            OS: begin
                cnt_d = '0;
                if (so_return) begin
                    state_d       = USER;
                    saved_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = USER;
                cnt_d   = '0;
            end
        endcase

        user_mode_d = (state_d == USER);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= USER;
            cnt_q         <= '0;
            user_mode_q   <= 1'b1;
            saved_pc_q    <= '0;
            saved_valid_q <= 1'b0;
            preempted_q   <= 1'b0;
            sw_cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            user_mode_q   <= user_mode_d;
            saved_pc_q    <= saved_pc_d;
            saved_valid_q <= saved_valid_d;
            preempted_q   <= preempted_d;
            sw_cnt_q      <= sw_cnt_d;
        end
    end

    assign pc_counter     = cnt_q;
    assign user_mode      = user_mode_q;
    assign saved_pc       = saved_pc_q;
    assign saved_pc_valid = saved_valid_q;
    assign preempted      = preempted_q;
    assign switch_count   = sw_cnt_q;

endmodule

// File: tb/tb_quantum_counter.sv
// Self-checking bench for quantum_counter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural process/OS model.
module tb_quantum_counter;

    localparam int Q    = 20;
    localparam int PCW  = 32;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            instr_retire = 1'b0;
    logic            stall = 1'b0;
    logic            enable_so = 1'b0;
    logic            end_proc = 1'b0;
    logic            so_return = 1'b0;
    logic [PCW-1:0]  pc_curr = '0;
    logic [4:0]      pc_counter;
    logic            user_mode;
    logic [PCW-1:0]  saved_pc;
    logic            saved_pc_valid;
    logic            preempted;
    logic [7:0]      switch_count;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: where the core is, what the OS was handed, and counts.
    typedef enum int { M_RUN, M_ENTERING_OS, M_IN_OS } where_e;
    where_e          m_where;
    int              m_retired;
    longint unsigned m_saved;
    bit              m_valid;
    bit              m_pre;
    int              m_switches;

    quantum_counter dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .instr_retire   (instr_retire),
        .stall          (stall),
        .enable_so      (enable_so),
        .end_proc       (end_proc),
        .so_return      (so_return),
        .pc_curr        (pc_curr),
        .pc_counter     (pc_counter),
        .user_mode      (user_mode),
        .saved_pc       (saved_pc),
        .saved_pc_valid (saved_pc_valid),
        .preempted      (preempted),
        .switch_count   (switch_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_where    = M_RUN;
        m_retired  = 0;
        m_saved    = 0;
        m_valid    = 0;
        m_pre      = 0;
        m_switches = 0;
    endtask

    task automatic model_step(input bit ret, input bit stl, input bit en, input bit endp,
                              input bit sor, input logic [PCW-1:0] pc);
        case (m_where)
            M_RUN: begin
                if (en) begin
                    m_saved    = pc;
                    m_valid    = 1;
                    m_pre      = (m_retired == Q) && !endp;
                    m_switches = (m_switches + 1) % 256;
                    m_retired  = 0;
                    m_where    = M_ENTERING_OS;
                end else if (ret && !stl) begin
                    m_retired = (m_retired + 1 > Q) ? Q : m_retired + 1;
                end
            end
            M_ENTERING_OS: m_where = M_IN_OS;
            M_IN_OS: if (sor) begin
                m_where = M_RUN;
                m_valid = 0;
            end
            default: ;
        endcase
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".pc_counter"},     64'(pc_counter),     64'(m_retired));
        check({ctx, ".user_mode"},      64'(user_mode),      64'(m_where == M_RUN));
        check({ctx, ".saved_pc"},       64'(saved_pc),       m_saved);
        check({ctx, ".saved_pc_valid"}, 64'(saved_pc_valid), 64'(m_valid));
        check({ctx, ".preempted"},      64'(preempted),      64'(m_pre));
        check({ctx, ".switch_count"},   64'(switch_count),   64'(m_switches));
    endtask

    // Called at a negedge: drive inputs, clock once, update model, compare at the next negedge.
    task automatic cycle(input bit ret, input bit stl, input bit en, input bit endp,
                         input bit sor, input logic [PCW-1:0] pc, input string ctx);
        instr_retire = ret;
        stall        = stl;
        enable_so    = en;
        end_proc     = endp;
        so_return    = sor;
        pc_curr      = pc;
        @(posedge clock);
        model_step(ret, stl, en, endp, sor, pc);
        @(negedge clock);
        compare_all(ctx);
    endtask

    task automatic idle(input string ctx);
        cycle(0, 0, 0, 0, 0, '0, ctx);
    endtask

    task automatic full_switch(input logic [PCW-1:0] pc);
        cycle(0, 0, 1, 1, 0, pc, "sw_req");
        idle("sw_enter");
        cycle(0, 0, 0, 0, 1, '0, "sw_ret");
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        model_reset();
        #1 compare_all("async_reset");
        #1 reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        compare_all("reset");
        reset_n = 1'b1;

        // 1: 20 retires step the counter, a 21st saturates.
        for (int i = 1; i <= 21; i++) begin
            cycle(1, 0, 0, 0, 0, '0, "count");
            check("count_const", 64'(pc_counter), 64'((i > 20) ? 20 : i));
        end
        check("count_user", 64'(user_mode), 64'd1);

        // 2: preemption at the quantum.
        cycle(0, 0, 1, 0, 0, 32'h40, "preempt");
        check("pre_saved",  64'(saved_pc),       64'h40);
        check("pre_valid",  64'(saved_pc_valid), 64'd1);
        check("pre_flag",   64'(preempted),      64'd1);
        check("pre_swcnt",  64'(switch_count),   64'd1);
        check("pre_cnt",    64'(pc_counter),     64'd0);
        check("pre_user",   64'(user_mode),      64'd0);
        cycle(0, 0, 1, 0, 1, 32'h99, "switch_ignores");
        check("switch_os_user", 64'(user_mode), 64'd0);
        cycle(0, 0, 0, 0, 1, '0, "os_return1");

        // 3: end_proc switch at count 7; retires in OS are not counted.
        repeat (7) cycle(1, 0, 0, 0, 0, '0, "to7");
        check("cnt7", 64'(pc_counter), 64'd7);
        cycle(0, 0, 1, 1, 0, 32'h88, "endproc");
        check("endp_saved", 64'(saved_pc),  64'h88);
        check("endp_flag",  64'(preempted), 64'd0);
        repeat (4) cycle(1, 0, 0, 0, 0, '0, "os_retire");
        check("os_cnt", 64'(pc_counter), 64'd0);

        // 5: repeated decision in OS ignored, then return.
        cycle(0, 0, 1, 0, 0, 32'h1234, "os_en_ignored");
        check("os_sw_hold",   64'(switch_count), 64'd2);
        check("os_pc_hold",   64'(saved_pc),     64'h88);
        cycle(0, 0, 0, 0, 1, '0, "os_return2");
        check("ret_user",  64'(user_mode),      64'd1);
        check("ret_valid", 64'(saved_pc_valid), 64'd0);
        check("ret_pc",    64'(saved_pc),       64'h88);

        // 4: stalled retires ignored; switch beats a same-cycle retire.
        cycle(0, 0, 0, 0, 1, '0, "user_soret_ignored");
        repeat (5) cycle(1, 1, 0, 0, 0, '0, "stalled");
        repeat (3) cycle(1, 0, 0, 0, 0, '0, "unstalled");
        check("stall_cnt", 64'(pc_counter), 64'd3);
        cycle(1, 0, 1, 0, 1, 32'h77, "en_and_retire");
        check("er_cnt",   64'(pc_counter),   64'd0);
        check("er_swcnt", 64'(switch_count), 64'd3);
        check("er_user",  64'(user_mode),    64'd0);
        idle("er_enter");
        cycle(0, 0, 0, 0, 1, '0, "er_ret");

        // 6a: 256 switches wrap the statistics counter.
        apply_reset();
        for (int i = 0; i < 256; i++) full_switch(32'(i * 4));
        check("wrap_swcnt", 64'(switch_count), 64'd0);

        // 6b: 255 switches, then asynchronous reset while in OS.
        apply_reset();
        for (int i = 0; i < 254; i++) full_switch(32'(i));
        cycle(0, 0, 1, 0, 0, 32'hdead_beef, "last_sw");
        idle("last_enter");
        check("pre_rst_swcnt", 64'(switch_count), 64'd255);
        apply_reset();
        check("rst_swcnt", 64'(switch_count), 64'd0);
        check("rst_user",  64'(user_mode),    64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(3) != 0), ($urandom_range(3) == 0),
                  ($urandom_range(15) == 0), $urandom_range(1) == 1,
                  ($urandom_range(3) == 0), $urandom, "rand");
            if ($urandom_range(999) == 0) apply_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
